// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse sequence store: sequence width,
// default depth, the invalid-sequence tag and the controller state encoding.
package morse_pkg;

  localparam int SEQ_W = 10;
  localparam int DEPTH_DEFAULT = 16;
  localparam logic [1:0] INVALID_TAG = 2'b11;

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  function automatic logic is_valid_seq(input logic [SEQ_W-1:0] seq);
    return seq[SEQ_W-1 -: 2] != INVALID_TAG;
  endfunction

endpackage

// File: rtl/seq_store_ctrl_if.sv
// Handshake bundle between the sequence separator, the store and the translator:
// an input pair channel and an output stream channel, both valid/ready.
interface seq_store_ctrl_if #(
  parameter int SEQ_W = morse_pkg::SEQ_W
);

  logic             in_valid;
  logic             in_ready;
  logic [SEQ_W-1:0] first_seq;
  logic [SEQ_W-1:0] sec_seq;
  logic             out_valid;
  logic             out_ready;
  logic [SEQ_W-1:0] out_seq;
  logic             out_last;

  modport master (
    output in_valid, first_seq, sec_seq, out_ready,
    input  in_ready, out_valid, out_seq, out_last
  );

  modport slave (
    input  in_valid, first_seq, sec_seq, out_ready,
    output in_ready, out_valid, out_seq, out_last
  );

endinterface

// File: rtl/seq_slot_array.sv
// DEPTH x W register file with two write ports and one combinational read port.
// Port 0 wins if both ports ever target the same slot.
module seq_slot_array #(
  parameter int DEPTH = 16,
  parameter int W = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr0_en,
  input  logic [AW-1:0] wr0_addr,
  input  logic [W-1:0]  wr0_data,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_addr,
  input  logic [W-1:0]  wr1_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] slots [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr0_en && wr0_addr == AW'(i)) begin
        slots[i] <= wr0_data;
      end else if (wr1_en && wr1_addr == AW'(i)) begin
        slots[i] <= wr1_data;
      end
    end
  end

  assign rd_data = slots[rd_addr];

endmodule

// File: rtl/seq_store_ctrl.sv
// Buffers captured Morse sequence pairs in arrival order and, on enter, streams
// them oldest-first to the translator; the buffer is empty once the stream ends.
module seq_store_ctrl
  import morse_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enter,
  seq_store_ctrl_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t           state, state_next;
  logic [AW-1:0]    rd, rd_next;
  logic [CW-1:0]    count_next, count_acc, wr_inc;
  logic             overflow_next;
  logic             v_first, v_sec, in_fire, out_fire, last_beat;
  logic             room_two, drop_sec;
  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_addr, wr1_addr;
  logic [SEQ_W-1:0] wr0_data, rd_data;

  seq_slot_array #(.DEPTH(DEPTH), .W(SEQ_W)) u_slots (
    .clk      (clk),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (bus.sec_seq),
    .rd_addr  (rd),
    .rd_data  (rd_data)
  );

  // Invalid sequences are skipped, so a lone valid sec_seq lands in slot count.
  always_comb begin
    v_first   = is_valid_seq(bus.first_seq);
    v_sec     = is_valid_seq(bus.sec_seq);
    in_fire   = bus.in_valid && bus.in_ready && !clear;
    room_two  = count < CW'(DEPTH - 1);
    wr0_en    = in_fire && (v_first || v_sec);
    wr1_en    = in_fire && v_first && v_sec && room_two;
    drop_sec  = in_fire && v_first && v_sec && !room_two;
    wr0_data  = v_first ? bus.first_seq : bus.sec_seq;
    wr0_addr  = count[AW-1:0];
    wr1_addr  = wr0_addr + AW'(1);
    wr_inc    = CW'(wr0_en) + CW'(wr1_en);
    count_acc = count + wr_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCEPT:  if (enter && count_acc != '0) state_next = DRAIN;
      DRAIN:   if (out_fire && last_beat) state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
    if (clear) state_next = ACCEPT;
  end

  always_comb begin
    bus.in_ready  = (state == ACCEPT) && !full && !reset;
    bus.out_valid = (state == DRAIN);
    bus.out_seq   = (state == DRAIN) ? rd_data : '1;
    last_beat     = (state == DRAIN) && ({1'b0, rd} == count - CW'(1));
    bus.out_last  = last_beat;
  end

  assign out_fire = bus.out_valid && bus.out_ready;

  // Count only moves while accepting; a drain holds it until the final beat.
  always_comb begin
    count_next    = count;
    rd_next       = rd;
    overflow_next = overflow;
    if (state == ACCEPT) begin
      count_next    = count_acc;
      rd_next       = '0;
      overflow_next = overflow | drop_sec;
    end else if (out_fire) begin
      if (last_beat) begin
        count_next    = '0;
        rd_next       = '0;
        overflow_next = 1'b0;
      end else begin
        rd_next = rd + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count    <= '0;
      rd       <= '0;
      overflow <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      count    <= count_next;
      rd       <= rd_next;
      overflow <= overflow_next;
      full     <= (count_next == CW'(DEPTH));
      empty    <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_seq_store_ctrl.sv
// Randomised plus directed bench for seq_store_ctrl: a queue-based reference
// model predicts the stream, a negedge monitor checks every presented beat.
module tb_seq_store_ctrl;
  import morse_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [SEQ_W-1:0] INV = '1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic             last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, clear, enter;
  logic [CW-1:0] count;
  logic          full, empty, overflow;

  seq_store_ctrl_if #(.SEQ_W(SEQ_W)) bus ();

  seq_store_ctrl #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .enter    (enter),
    .bus      (bus.slave),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: stored entries, pending beats and drain bookkeeping.
  beat_t            exp_q[$];
  logic [SEQ_W-1:0] mbuf[$];
  bit               mdrain = 1'b0;
  bit               movf = 1'b0;
  int               mcount = 0;
  int               mrem = 0;

  function automatic bit seq_ok(input logic [SEQ_W-1:0] s);
    return s[SEQ_W-1] !== 1'b1 || s[SEQ_W-2] !== 1'b1;
  endfunction

  function automatic logic [SEQ_W-1:0] rand_valid();
    logic [1:0] tag;
    tag = 2'($urandom_range(0, 2));
    return {tag, 8'($urandom)};
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int exp_cnt;
    exp_cnt = mdrain ? mcount : mbuf.size();
    compare("count", 32'(count), 32'(exp_cnt));
    compare("full", 32'(full), 32'(exp_cnt == DEPTH));
    compare("empty", 32'(empty), 32'(exp_cnt == 0));
    compare("overflow", 32'(overflow), 32'(movf));
    compare("in_ready", 32'(bus.in_ready), 32'(!reset && !mdrain && mbuf.size() < DEPTH));
    compare("out_valid", 32'(bus.out_valid), 32'(mdrain));
    if (!mdrain) compare("idle_out_seq", 32'(bus.out_seq), 32'(INV));
  endtask

  task automatic model_edge(input bit iv, input logic [SEQ_W-1:0] f, input logic [SEQ_W-1:0] s,
                            input bit en, input bit clr, input bit ordy);
    if (reset || clr) begin
      mbuf.delete();
      exp_q.delete();
      mdrain = 1'b0;
      movf = 1'b0;
      mcount = 0;
      mrem = 0;
    end else if (mdrain) begin
      if (ordy) begin
        mrem--;
        if (mrem == 0) begin
          mdrain = 1'b0;
          movf = 1'b0;
        end
      end
    end else begin
      if (iv && mbuf.size() < DEPTH) begin
        if (seq_ok(f)) mbuf.push_back(f);
        if (seq_ok(s)) begin
          if (mbuf.size() < DEPTH) mbuf.push_back(s);
          else movf = 1'b1;
        end
      end
      if (en && mbuf.size() > 0) begin
        foreach (mbuf[i]) exp_q.push_back('{seq: mbuf[i], last: (i == mbuf.size() - 1)});
        mcount = mbuf.size();
        mrem = mcount;
        mbuf.delete();
        mdrain = 1'b1;
      end
    end
  endtask

  // One cycle: drive after the edge, check at negedge, advance the model at the edge.
  task automatic applyStimulus(input bit iv, input logic [SEQ_W-1:0] f, input logic [SEQ_W-1:0] s,
                               input bit en, input bit clr, input bit ordy);
    bus.in_valid  = iv;
    bus.first_seq = f;
    bus.sec_seq   = s;
    enter         = en;
    clear         = clr;
    bus.out_ready = ordy;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    model_edge(iv, f, s, en, clr, ordy);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, INV, INV, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic fill_pairs(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, rand_valid(), rand_valid(), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input bit random_ready);
    int guard;
    guard = 0;
    while (mdrain && guard < 200) begin
      applyStimulus(1'($urandom_range(0, 1)), rand_valid(), rand_valid(),
                    1'($urandom_range(0, 1)), 1'b0,
                    random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
    if (mdrain) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL drain_timeout: stream still open after %0d cycles", guard);
      mdrain = 1'b0;
    end
  endtask

  // Scoreboard side: every beat the DUT presents must match the head of exp_q.
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_beat: got %0h, expected no beat at %0t", bus.out_seq, $time);
      end else begin
        compare("out_seq", 32'(bus.out_seq), 32'(exp_q[0].seq));
        compare("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    enter = 1'b0;
    bus.in_valid = 1'b0;
    bus.first_seq = INV;
    bus.sec_seq = INV;
    bus.out_ready = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);

    $display("[TB] basic pair capture and stream");
    applyStimulus(1'b1, 10'h005, 10'h00A, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 10'h3C0, 10'h012, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, INV, INV, 1'b1, 1'b0, 1'b1);
    drain(1'b0);
    idle(1);

    $display("[TB] fill to DEPTH with overflow");
    fill_pairs(7);
    applyStimulus(1'b1, rand_valid(), INV, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 10'h001, 10'h002, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 10'h003, 10'h004, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, INV, INV, 1'b1, 1'b0, 1'b1);
    drain(1'b0);
    idle(1);

    $display("[TB] enter on empty buffer and same-cycle write");
    applyStimulus(1'b0, INV, INV, 1'b1, 1'b0, 1'b1);
    idle(2);
    applyStimulus(1'b1, 10'h004, INV, 1'b1, 1'b0, 1'b1);
    drain(1'b0);
    idle(1);

    $display("[TB] stalled drain with ignored input");
    fill_pairs(2);
    applyStimulus(1'b0, INV, INV, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_valid(), rand_valid(), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, rand_valid(), rand_valid(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_valid(), rand_valid(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_valid(), rand_valid(), 1'b0, 1'b0, 1'b1);
    drain(1'b0);
    idle(1);

    $display("[TB] clear mid-drain and with overflow pending");
    fill_pairs(2);
    applyStimulus(1'b0, INV, INV, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, INV, INV, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, INV, INV, 1'b0, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b1, 10'h021, 10'h022, 1'b0, 1'b0, 1'b1);
    fill_pairs(8);
    applyStimulus(1'b0, INV, INV, 1'b0, 1'b1, 1'b1);
    idle(1);

    $display("[TB] reset while holding seven entries");
    fill_pairs(3);
    applyStimulus(1'b1, INV, rand_valid(), 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, INV, INV, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    idle(2);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), SEQ_W'($urandom), SEQ_W'($urandom),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                    1'($urandom_range(0, 1)));
    end
    drain(1'b0);
    idle(3);
    compare("pending_beats", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
